mux_fifo_rr: RTL
================

# mux_fifo_rr

Parametrised multi-channel buffered merge: NCHAN independent input streams, each with its own DEPTH-entry FIFO, drained onto one valid/ready output stream by a round-robin or fixed-priority arbiter. It is the next-generation front-end merge stage, generalised in width, depth, channel count and arbitration mode. It sits between per-source producers and a single downstream consumer. It is also the vlog front-end's reference exercise for generate loops, packed/unpacked arrays, functions and always_ff/always_comb.

## Interface
- WIDTH, 8, data bits per entry (≥1)
- DEPTH, 4, entries per channel FIFO (power of two, ≥2)
- NCHAN, 4, number of input channels (≥2)
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  NCHAN  per-channel push request
- in_ready  out  NCHAN  per-channel not-full
- in_data  in  NCHAN*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  head entry of granted channel
- out_chan  out  $clog2(NCHAN)  index of granted channel
- level  out  NCHAN*($clog2(DEPTH)+1)  per-channel occupancy, channel c at [c*LW +: LW]

## Operation
- Push on channel c when in_valid[c] && in_ready[c]. in_ready[c] = (level[c] != DEPTH). It is derived from registered state only, so there is no combinational path from any input to in_ready.
- Full channel: in_ready[c] = 0 even if the same channel is popped that cycle. The freed slot is visible next cycle.
- Pop when out_valid && out_ready. The entry is removed from channel out_chan.
- out_valid = (lock) || (any level != 0).
- Grant, PRIO_MODE=0: first non-empty channel searching upward from rr_ptr+1, modulo NCHAN.
- Grant, PRIO_MODE=1: lowest-index non-empty channel.
- Lock: if out_valid && !out_ready, the grant is registered and held. out_chan and out_data must not change until the transfer completes, even if a higher-priority channel becomes non-empty.
- rr_ptr updates to out_chan on every transfer and is unchanged otherwise. It is unused in PRIO_MODE=1.
- Simultaneous push and pop on the same non-full channel: level is unchanged, both pointers advance.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally. level is one bit wider so that DEPTH is representable.
- out_data and out_chan are forced to 0 whenever out_valid = 0. Storage is not reset.
- Reset (async assert, sync-safe deassert by the system) clears:
  - all levels and pointers to 0, and lock to 0
  - rr_ptr to NCHAN-1, so channel 0 has first priority
- Resulting reset values: in_ready all 1; out_valid 0; out_data 0; out_chan 0; level all 0.
- Reset mid-operation discards all buffered entries. The first cycle after deassert behaves as after power-up.

## Timing
- Push-to-output latency: 1 cycle. An entry pushed at edge N is presented on out_data after edge N, if it is granted.
- Back-to-back pops: 1 per cycle with out_ready held high.
- out_valid, out_data and out_chan depend combinationally on registered state only. out_ready only affects the next state.
- in_ready deasserts in the cycle after the push that fills the channel.

## Structure
- Package mux_fifo_pkg holds:
  - function rr_pick(req, ptr, mode), returning the grant index
  - localparam helpers for pointer and level widths
  - the typedef for the level field
- Sub-module chan_fifo (WIDTH, DEPTH) implements one channel. It has push, pop, head data, level and full, with storage as an unpacked array of WIDTH-bit words.
- mux_fifo_rr instantiates NCHAN chan_fifo copies in a generate-for, plus the arbiter and lock register.

## Test plan
- Reset then idle: check in_ready=4'b1111, out_valid=0, out_data=0, level all 0. Assert rst_n low mid-burst: all of these return within the same cycle.
- Fill channel 2 with 8'h10..8'h13 (DEPTH=4) and hold out_ready=0: in_ready[2]=0 after the 4th push, level[2]=4, out_data=8'h10 and out_chan=2 stable.
- Channels 0, 1 and 3 each hold 2 entries, out_ready=1, PRIO_MODE=0: output channel order 0,1,3,0,1,3, one per cycle.
- Same load with PRIO_MODE=1: order 0,0,1,1,3,3.
- Lock: grant channel 3 with out_ready=0, then push into channel 0. out_chan stays 3 until accepted, and channel 0 is served next.
- Full channel with simultaneous pop and push attempt: the push is refused (in_ready=0) and level drops to 3. The next-cycle push is accepted and level returns to 4.

Source files
------------

// File: rtl/mux_fifo_pkg.sv
// Shared helpers for the multi-channel buffered merge.
//   ptr_w / lvl_w : pointer and level widths derived from FIFO depth
//   level_t       : widest level field any configuration can use
//   rr_pick       : grant selection, round-robin or fixed priority
package mux_fifo_pkg;

  localparam int unsigned MAX_CHAN  = 32;
  localparam int unsigned MAX_LVL_W = 16;

  typedef logic [MAX_LVL_W-1:0] level_t;

  // Read/write pointer width; pointers wrap naturally at DEPTH.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Level width, one bit wider than the pointer so DEPTH is representable.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // mode=0: first requester searching upward from ptr+1 (mod nchan).
  // mode=1: lowest-index requester. Returns 0 when nothing requests.
  function automatic int unsigned rr_pick(input logic [MAX_CHAN-1:0] req,
                                          input int unsigned         ptr,
                                          input int unsigned         nchan,
                                          input logic                mode);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned i = 0; i < nchan; i++) begin
      if (mode) begin
        idx = i;
      end else begin
        idx = ptr + 1 + i;
        if (idx >= nchan) idx = idx - nchan;
      end
      if (!found && req[5'(idx)]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// One channel FIFO of the merge stage.
//   clk, rst_n : clock, async active-low reset (pointers/level only)
//   push/wdata : write; caller guarantees not full
//   pop        : remove head; caller guarantees not empty
//   rdata      : current head entry
//   level/full : occupancy and full flag, from registered state
module chan_fifo
  import mux_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;

  // Storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign level = cnt;
  assign full  = (cnt == LW'(DEPTH));

endmodule

// File: rtl/mux_fifo_rr.sv
// Multi-channel buffered merge: NCHAN FIFOs drained onto one valid/ready
// stream by a round-robin (PRIO_MODE=0) or fixed-priority (1) arbiter.
//   in_valid/in_ready/in_data : per-channel push side, in_ready = not full
//   out_valid/out_ready       : merged output handshake
//   out_data/out_chan         : head entry and its channel, 0 when idle
//   level                     : per-channel occupancy, LW bits each
module mux_fifo_rr
  import mux_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NCHAN     = 4,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NCHAN-1:0]                  in_valid,
  output logic [NCHAN-1:0]                  in_ready,
  input  logic [NCHAN*WIDTH-1:0]            in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_data,
  output logic [$clog2(NCHAN)-1:0]          out_chan,
  output logic [NCHAN*lvl_w(DEPTH)-1:0]     level
);

  localparam int unsigned CW = $clog2(NCHAN);
  localparam int unsigned LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] head [NCHAN];
  logic [LW-1:0]    lvl  [NCHAN];
  logic [NCHAN-1:0] full;
  logic [NCHAN-1:0] nonempty;
  logic [NCHAN-1:0] push;
  logic [NCHAN-1:0] pop;

  logic          lock_q,     lock_d;
  logic [CW-1:0] lock_chan_q, lock_chan_d;
  logic [CW-1:0] rr_ptr_q,   rr_ptr_d;
  logic [CW-1:0] pick;
  logic [CW-1:0] gnt;
  logic          valid;
  logic          xfer;

  // Per-channel FIFOs; push is gated by registered full only.
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[c]),
      .pop   (pop[c]),
      .wdata (in_data[c*WIDTH +: WIDTH]),
      .rdata (head[c]),
      .level (lvl[c]),
      .full  (full[c])
    );
    assign nonempty[c]         = (lvl[c] != '0);
    assign in_ready[c]         = ~full[c];
    assign push[c]             = in_valid[c] & ~full[c];
    assign pop[c]              = xfer & (gnt == CW'(c));
    assign level[c*LW +: LW]   = lvl[c];
  end

  // Arbiter state: held grant while stalled, round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
      rr_ptr_q    <= CW'(NCHAN - 1);
    end else begin
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Grant selection and next arbiter state.
  always_comb begin
    pick        = CW'(rr_pick(MAX_CHAN'(nonempty), 32'(rr_ptr_q), NCHAN,
                              PRIO_MODE != 0));
    gnt         = lock_q ? lock_chan_q : pick;
    valid       = lock_q | (|nonempty);
    xfer        = valid & out_ready;
    lock_d      = valid & ~out_ready;
    lock_chan_d = gnt;
    rr_ptr_d    = xfer ? gnt : rr_ptr_q;
  end

  assign out_valid = valid;
  assign out_chan  = valid ? gnt : '0;
  assign out_data  = valid ? head[gnt] : '0;

endmodule
